// File: rtl/stream_pattern_pkg.sv
// Shared types and constants for the stream pattern master: pattern modes,
// FSM states and the Galois LFSR tap masks.
package stream_pattern_pkg;

    typedef enum logic [1:0] {
        INCR  = 2'd0,
        CONST = 2'd1,
        LFSR  = 2'd2,
        WALK  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Right-shifting Galois masks for maximal-length polynomials.
    localparam logic [63:0] LFSR_TAPS_8  = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400;
    localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003;
    localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            8:       return LFSR_TAPS_8;
            16:      return LFSR_TAPS_16;
            64:      return LFSR_TAPS_64;
            default: return LFSR_TAPS_32;
        endcase
    endfunction

endpackage

// File: rtl/stream_pattern_master_if.sv
// Stream bus between the pattern master and its sink.
// A beat transfers on a rising edge where tvalid & tready; once tvalid is high
// the source holds tvalid, tdata and tlast unchanged until that transfer.
interface stream_pattern_master_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_lfsr.sv
// Galois LFSR register: loads a seed (zero replaced by one) and steps once
// per advance pulse.
module stream_lfsr
    import stream_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] value
);
    localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= (seed == '0) ? DATA_WIDTH'(1) : seed;
        end else if (advance) begin
            value <= (value >> 1) ^ (value[0] ? TAPS : '0);
        end
    end
endmodule

// File: rtl/stream_pattern_master.sv
// Stream pattern generator: emits pkt_num packets of pkt_len beats with a
// selectable data pattern and a programmable idle gap between packets.
module stream_pattern_master
    import stream_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [CNT_WIDTH-1:0]  pkt_num,
    input  logic [GAP_WIDTH-1:0]  gap,
    stream_pattern_master_if.master axis,
    output logic                  busy,
    output logic                  done,
    output state_t                state_dbg
);
    state_t                state_q, state_d;
    mode_t                 mode_q;
    logic [LEN_WIDTH-1:0]  len_q, beat_cnt;
    logic [CNT_WIDTH-1:0]  num_q, pkt_cnt;
    logic [GAP_WIDTH-1:0]  gap_q, gap_cnt;
    logic [DATA_WIDTH-1:0] data_q, lfsr_value;
    logic                  launch, accept, last_beat, last_pkt, gap_end;

    assign launch    = (state_q == IDLE) && start;
    assign accept    = (state_q == SEND) && axis.tready;
    assign last_beat = (beat_cnt == len_q - LEN_WIDTH'(1));
    assign last_pkt  = (pkt_cnt == num_q - CNT_WIDTH'(1));
    assign gap_end   = (gap_cnt == gap_q - GAP_WIDTH'(1));
    assign state_dbg = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (pkt_num == '0) ? DONE : SEND;
            SEND: if (accept && last_beat)
                      state_d = last_pkt ? DONE : ((gap_q == '0) ? SEND : GAP);
            GAP:  if (gap_end) state_d = SEND;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore decode of the state and counter flops; no input reaches an output.
    always_comb begin
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        axis.tdata  = (mode_q == LFSR) ? lfsr_value : data_q;
        case (state_q)
            SEND: begin
                axis.tvalid = 1'b1;
                axis.tlast  = last_beat;
                busy        = 1'b1;
            end
            GAP:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= INCR;
            len_q    <= '0;
            num_q    <= '0;
            gap_q    <= '0;
            beat_cnt <= '0;
            pkt_cnt  <= '0;
            gap_cnt  <= '0;
            data_q   <= '0;
        end else begin
            if (launch) begin
                mode_q   <= mode_t'(mode);
                len_q    <= (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
                num_q    <= pkt_num;
                gap_q    <= gap;
                beat_cnt <= '0;
                pkt_cnt  <= '0;
                data_q   <= (mode_t'(mode) == WALK) ? DATA_WIDTH'(1) : seed;
            end
            if (accept) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + LEN_WIDTH'(1);
                if (last_beat) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
                case (mode_q)
                    INCR:    data_q <= data_q + DATA_WIDTH'(1);
                    WALK:    data_q <= {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]};
                    default: ;
                endcase
            end
            // Counts only while idling between packets; zero on every GAP entry.
            gap_cnt <= (state_q == GAP) ? gap_cnt + GAP_WIDTH'(1) : '0;
        end
    end

    stream_lfsr #(.DATA_WIDTH(DATA_WIDTH)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (launch),
        .seed    (seed),
        .advance (accept && (mode_q == LFSR)),
        .value   (lfsr_value)
    );
endmodule

// File: tb/tb_stream_pattern_master.sv
// Self-checking bench for stream_pattern_master: table-driven runs with a
// scoreboard queue, plus directed timing, WALK wrap and reset sequences.
module tb_stream_pattern_master;
    import stream_pattern_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] seed;
    logic [15:0] pkt_len;
    logic [15:0] pkt_num;
    logic [7:0]  gap;
    logic        busy, done;
    state_t      state_dbg;

    logic        start8;
    logic        busy8, done8;
    state_t      state8;
    logic [1:0]  mode8 = 2'd3;
    logic [7:0]  seed8 = 8'h5A;
    logic [15:0] len8  = 16'd10;
    logic [15:0] num8  = 16'd1;
    logic [7:0]  gap8  = 8'd0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] exp_q[$];

    typedef struct {
        mode_t       mode;
        logic [31:0] seed;
        logic [15:0] len;
        logic [15:0] num;
        logic [7:0]  gap;
        int          stall;
        int          exp_beats;
        int          exp_idle;
        bit          chk_last;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[10];

    stream_pattern_master_if #(.DATA_WIDTH(32)) sif ();
    stream_pattern_master_if #(.DATA_WIDTH(8))  sif8 ();

    stream_pattern_master dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .pkt_len(pkt_len), .pkt_num(pkt_num), .gap(gap), .axis(sif.master),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    stream_pattern_master #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .seed(seed8),
        .pkt_len(len8), .pkt_num(num8), .gap(gap8), .axis(sif8.master),
        .busy(busy8), .done(done8), .state_dbg(state8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // x^32+x^22+x^2+x+1 in right-shifting Galois form.
    function automatic logic [31:0] next_val(input mode_t m, input logic [31:0] v);
        case (m)
            INCR:    return v + 32'd1;
            LFSR:    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
            WALK:    return {v[30:0], v[31]};
            default: return v;
        endcase
    endfunction

    task automatic push_expected(input mode_t m, input logic [31:0] s,
                                 input logic [15:0] l, input logic [15:0] n);
        int          len_eff;
        logic [31:0] v;
        len_eff = (l == 16'd0) ? 1 : int'(l);
        v = (m == WALK) ? 32'd1 : ((m == LFSR && s == 32'd0) ? 32'd1 : s);
        for (int p = 0; p < int'(n); p++) begin
            for (int b = 0; b < len_eff; b++) begin
                exp_q.push_back({(b == len_eff - 1), v});
                v = next_val(m, v);
            end
        end
    endtask

    task automatic launch(input mode_t m, input logic [31:0] s, input logic [15:0] l,
                          input logic [15:0] n, input logic [7:0] g);
        @(posedge clk); #1;
        start = 1'b1; mode = m; seed = s; pkt_len = l; pkt_num = n; gap = g;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 2'($urandom_range(0, 3)); seed = $urandom;
        pkt_len = 16'($urandom); pkt_num = 16'($urandom); gap = 8'($urandom);
    endtask

    task automatic run_vec(input vec_t v, output int beats, output int idle,
                           output logic [31:0] last);
        bit finished = 1'b0;
        beats = 0; idle = 0; last = '0;
        push_expected(v.mode, v.seed, v.len, v.num);
        launch(v.mode, v.seed, v.len, v.num, v.gap);
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            case (v.stall)
                0:       sif.tready = 1'b1;
                1:       sif.tready = (cyc % 2 == 0);
                default: sif.tready = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            if (busy && !sif.tvalid) idle++;
            if (sif.tvalid && sif.tready) begin
                beats++;
                last = sif.tdata;
            end
            if (done) finished = 1'b1;
            @(posedge clk); #1;
        end
        if (!finished) begin
            n_tests++; n_fail++;
            $display("FAIL run_timeout: no done within 2000 cycles");
        end
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        check("idle_after_done", {62'd0, busy, done}, 64'd0);
    endtask

    // Scoreboard side: pop on every transfer, and hold-check across stalls.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {31'd0, sif.tvalid, sif.tlast, sif.tdata},
                      {31'd0, 1'b1, prev_last, prev_data});
            if (sif.tvalid && sif.tready) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL extra_beat: got 0x%0h, expected no beat", sif.tdata);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("beat", {31'd0, sif.tlast, sif.tdata}, {31'd0, e});
                end
            end
            prev_stall = sif.tvalid && !sif.tready;
            prev_data  = sif.tdata;
            prev_last  = sif.tlast;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          beats, idle, k8;
        logic [31:0] last;
        logic [7:0]  walk_exp[10];
        bit          fin8;

        vecs[0] = '{INCR,  32'd5,          16'd3,  16'd2, 8'd0, 0, 6,  1,  1'b1, 32'd10};
        vecs[1] = '{CONST, 32'hA5,         16'd4,  16'd1, 8'd0, 1, 4,  1,  1'b1, 32'hA5};
        vecs[2] = '{INCR,  32'hFFFF_FFFE,  16'd2,  16'd2, 8'd3, 0, 4,  4,  1'b1, 32'd1};
        vecs[3] = '{WALK,  32'h1234,       16'd34, 16'd1, 8'd0, 2, 34, 1,  1'b1, 32'd2};
        vecs[4] = '{LFSR,  32'd0,          16'd1,  16'd2, 8'd2, 0, 2,  3,  1'b1, 32'h8020_0003};
        vecs[5] = '{INCR,  32'd7,          16'd0,  16'd3, 8'd1, 2, 3,  3,  1'b1, 32'd9};
        vecs[6] = '{INCR,  32'd5,          16'd5,  16'd0, 8'd0, 0, 0,  1,  1'b0, 32'd0};
        vecs[7] = '{CONST, 32'd0,          16'd2,  16'd3, 8'd5, 2, 6,  11, 1'b1, 32'd0};
        vecs[8] = '{LFSR,  32'd2,          16'd2,  16'd1, 8'd0, 1, 2,  1,  1'b1, 32'd1};
        vecs[9] = '{LFSR,  32'hDEAD_BEEF,  16'd8,  16'd2, 8'd0, 2, 16, 1,  1'b0, 32'd0};
        walk_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};

        // Clock/reset
        rst = 1'b1; start = 1'b0; start8 = 1'b0; mode = '0; seed = '0;
        pkt_len = '0; pkt_num = '0; gap = '0;
        sif.tready = 1'b0; sif8.tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {60'd0, sif.tvalid, sif.tlast, busy, done}, 64'd0);
        check("reset_tdata", 64'(sif.tdata), 64'd0);
        check("reset_state", 64'(state_dbg), 64'(IDLE));
        @(posedge clk); #1;
        rst = 1'b0;

        // Exact cycle timing, start ignored while busy and in DONE
        sif.tready = 1'b1;
        push_expected(INCR, 32'd5, 16'd3, 16'd2);
        launch(INCR, 32'd5, 16'd3, 16'd2, 8'd0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("timing_tvalid", 64'(sif.tvalid), 64'(k <= 6));
            check("timing_tlast",  64'(sif.tlast),  64'(k == 3 || k == 6));
            check("timing_done",   64'(done),       64'(k == 7));
            check("timing_busy",   64'(busy),       64'(k <= 7));
            @(posedge clk); #1;
            start = (k == 3 || k == 6);
            seed  = 32'h0BAD_0000;
        end
        start = 1'b0;
        check("timing_drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Table-driven runs
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], beats, idle, last);
            check($sformatf("vec%0d_beats", i), 64'(beats), 64'(vecs[i].exp_beats));
            check($sformatf("vec%0d_idle", i),  64'(idle),  64'(vecs[i].exp_idle));
            if (vecs[i].chk_last)
                check($sformatf("vec%0d_last", i), 64'(last), 64'(vecs[i].exp_last));
        end

        // WALK wrap on an 8-bit instance
        @(posedge clk); #1; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        k8 = 0; fin8 = 1'b0;
        for (int c = 0; c < 40 && !fin8; c++) begin
            @(negedge clk);
            if (sif8.tvalid) begin
                if (k8 < 10) begin
                    check("walk8_data", 64'(sif8.tdata), 64'(walk_exp[k8]));
                    check("walk8_last", 64'(sif8.tlast), 64'(k8 == 9));
                end
                k8++;
            end
            if (done8) fin8 = 1'b1;
        end
        check("walk8_beats", 64'(k8), 64'd10);
        check("walk8_done", 64'(fin8), 64'd1);

        // Reset during the second beat abandons the run
        sif.tready = 1'b1;
        push_expected(INCR, 32'd100, 16'd4, 16'd1);
        launch(INCR, 32'd100, 16'd4, 16'd1, 8'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ctrl", {60'd0, sif.tvalid, sif.tlast, busy, done}, 64'd0);
        check("rst_async_tdata", 64'(sif.tdata), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            vec_t fresh;
            fresh = '{INCR, 32'd0, 16'd4, 16'd1, 8'd0, 0, 4, 1, 1'b1, 32'd3};
            run_vec(fresh, beats, idle, last);
            check("post_rst_beats", 64'(beats), 64'd4);
            check("post_rst_last",  64'(last),  64'd3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_pattern_master.md
STREAM_PATTERN_MASTER -- requirements
Module: stream_pattern_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, tdata/seed width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, beats-per-packet field width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, packet-count field width.
REQ-004 SHALL have parameter GAP_WIDTH, default 8, inter-packet idle-cycle field width.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  one-cycle launch pulse, sampled only in IDLE.
REQ-008 mode  input  2  pattern select, pkg enum: INCR=0, CONST=1, LFSR=2, WALK=3.
REQ-009 seed  input  DATA_WIDTH  first data value (INCR/CONST/LFSR).
REQ-010 pkt_len  input  LEN_WIDTH  beats per packet.
REQ-011 pkt_num  input  CNT_WIDTH  packets per run.
REQ-012 gap  input  GAP_WIDTH  idle cycles between packets.
REQ-013 tdata  output  DATA_WIDTH  stream payload.
REQ-014 tvalid  output  1  stream valid.
REQ-015 tlast  output  1  last beat of packet.
REQ-016 tready  input  1  downstream ready.
REQ-017 busy  output  1  high from cycle after accepted start until done.
REQ-018 done  output  1  one-cycle pulse at end of run.

Function
REQ-019 SHALL implement FSM IDLE -> SEND -> (GAP -> SEND)* -> DONE -> IDLE; all outputs registered.
REQ-020 IDLE: start=1 latches mode, seed, pkt_len, pkt_num, gap; later input changes ignored until next IDLE.
REQ-021 pkt_len=0 SHALL be treated as 1; pkt_num=0 SHALL go IDLE -> DONE directly with no beats, busy high one cycle.
REQ-022 tvalid SHALL rise the cycle after accepted start (latency 1).
REQ-023 Beat accepted when tvalid & tready; while tvalid & !tready, tdata/tlast SHALL hold stable and tvalid SHALL stay high.
REQ-024 tlast SHALL be high on beat index pkt_len-1 of every packet, low otherwise.
REQ-025 INCR: first beat = seed, +1 per accepted beat modulo 2^DATA_WIDTH, continuing across packets (no restart per packet).
REQ-026 CONST: every beat = seed.
REQ-027 LFSR: first beat = seed (seed 0 replaced by 1); Galois LFSR advances one step per accepted beat, taps per width from package.
REQ-028 WALK: first beat = 1 (bit 0), rotate left one bit per accepted beat, wrapping MSB -> bit 0; seed ignored.
REQ-029 After tlast accepted with packets remaining: gap=0 -> next packet's first beat valid next cycle (back-to-back); gap=N -> tvalid low exactly N cycles in GAP.
REQ-030 After final tlast accepted: tvalid low next cycle, DONE for one cycle with done=1, then IDLE, busy=0.
REQ-031 start asserted while busy SHALL be ignored; start in DONE cycle ignored.
REQ-032 Counters: beat counter LEN_WIDTH, packet counter CNT_WIDTH, gap counter GAP_WIDTH; no overflow when fields at max.

Reset
REQ-033 rst=1 SHALL immediately force IDLE; tvalid, tlast, busy, done = 0; tdata = 0; all counters and latched config = 0.
REQ-034 Reset mid-packet SHALL abandon the run with no trailing tlast; first post-reset run behaves as fresh.

Structure
REQ-035 Package stream_pattern_pkg SHALL hold mode enum, FSM state enum, and LFSR tap constants for widths 8/16/32/64.
REQ-036 Sub-module stream_lfsr (DATA_WIDTH param; load, seed, advance, value) SHALL implement the LFSR step.

Verification
REQ-037 INCR, seed=5, pkt_len=3, pkt_num=2, gap=0, tready=1 -> tdata 5,6,7,8,9,10 on consecutive cycles, tlast on 7 and 10, done one cycle after 10.
REQ-038 CONST, seed=0xA5, pkt_len=4, pkt_num=1, tready toggling 1/0 -> four 0xA5 beats, tdata/tvalid/tlast stable during stalls, tlast on 4th.
REQ-039 WALK, DATA_WIDTH=8, pkt_len=10, pkt_num=1 -> 0x01,0x02,...,0x80,0x01,0x02; tlast on 0x02.
REQ-040 INCR, seed=0xFFFFFFFE, pkt_len=2, pkt_num=2, gap=3 -> 0xFFFFFFFE,0xFFFFFFFF, 3 cycles tvalid=0, then 0x0,0x1.
REQ-041 pkt_num=0 -> no tvalid, busy high one cycle, done pulse; start during busy of a normal run -> run unchanged.
REQ-042 rst pulsed during second beat of 4-beat packet -> tvalid/busy drop asynchronously; next start with seed=0 (INCR) yields 0,1,2,3.
